led_instr_issuer: RTL and testbench

LED_INSTR_ISSUER -- requirements
Module: led_instr_issuer

---
 rtl/led_instr_issuer.sv | 122 ++++++++++++
 tb/tb_led_instr_issuer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/led_instr_issuer.sv
// led_instr_issuer: debounces four active-low keys and issues one LED-matrix instruction per press, waiting for done or timing out.
//   clk, rst        : system clock, synchronous active-high reset
//   w_key_1..4      : raw asynchronous keys, 0 = pressed
//   w_done          : controller completion pulse
//   w_start         : one-cycle request pulse
//   w_instruction   : {mode[7:0], row, column}, held until the next request
//   w_busy          : request outstanding
//   w_timeout       : one-cycle pulse when the controller never answered
module led_instr_issuer #(
    parameter int p_frequency   = 50_000_000,
    parameter int p_debounce_ms = 20,
    parameter int p_timeout_ms  = 3000,
    parameter int p_row_num     = 8,
    parameter int p_column_num  = 8,
    localparam int IW = 8 + p_row_num + p_column_num
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          w_key_1,
    input  logic          w_key_2,
    input  logic          w_key_3,
    input  logic          w_key_4,
    input  logic          w_done,
    output logic          w_start,
    output logic [IW-1:0] w_instruction,
    output logic          w_busy,
    output logic          w_timeout
);
    localparam longint DB_L = longint'(p_frequency) * p_debounce_ms / 1000;
    localparam longint TO_L = longint'(p_frequency) * p_timeout_ms / 1000;
    localparam int DB = int'(DB_L);
    localparam int TO = int'(TO_L);
    localparam int DW = DB > 1 ? $clog2(DB) : 1;
    localparam int TW = TO > 1 ? $clog2(TO) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

    state_t          state;
    logic [3:0]      keys;
    logic [3:0]      sync_1;
    logic [3:0]      sync_2;
    logic [3:0]      deb;
    logic [3:0]      deb_q;
    logic [3:0]      ev;
    logic [DW-1:0]   db_cnt [4];
    logic [TW-1:0]   to_cnt;
    logic [IW-1:0]   enc;

    assign keys = {w_key_4, w_key_3, w_key_2, w_key_1};
    // press = debounced level fell on the previous edge; release is ignored
    assign ev   = deb_q & ~deb;

    always_comb begin
        enc = ev[0] ? {8'h01, p_row_num'(8'b0000_1000), p_column_num'(8'b0000_0100)} :
              ev[1] ? {8'h02, p_row_num'(8'b0010_0000), p_column_num'(8'b1111_1111)} :
              ev[2] ? {8'h03, p_row_num'(8'b0000_0001), p_column_num'(8'b0000_0100)} :
                      {8'h04, p_row_num'(8'b0000_1000), p_column_num'(8'b0000_0100)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= '0;
            sync_2 <= '0;
            deb    <= '1;
            deb_q  <= '1;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            sync_1 <= keys;
            sync_2 <= sync_1;
            deb_q  <= deb;
            // any agreement with the current level restarts the stability count
            for (int i = 0; i < 4; i++) begin
                if (sync_2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DB - 1)) begin
                    db_cnt[i] <= '0;
                    deb[i]    <= sync_2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            w_start       <= 1'b0;
            w_busy        <= 1'b0;
            w_timeout     <= 1'b0;
            w_instruction <= '0;
            to_cnt        <= '0;
        end else begin
            w_start   <= 1'b0;
            w_timeout <= 1'b0;
            case (state)
                ST_IDLE: if (|ev) begin
                    w_instruction <= enc;
                    w_start       <= 1'b1;
                    w_busy        <= 1'b1;
                    to_cnt        <= '0;
                    state         <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    to_cnt <= '0;
                    state  <= ST_WAIT;
                end
                ST_WAIT: if (w_done) begin
                    w_busy <= 1'b0;
                    state  <= ST_DONE;
                end else if (to_cnt == TW'(TO - 1)) begin
                    w_timeout <= 1'b1;
                    w_busy    <= 1'b0;
                    state     <= ST_DONE;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
                ST_DONE: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_led_instr_issuer.sv
// tb_led_instr_issuer: directed bench for led_instr_issuer with 4-cycle debounce and 20-cycle timeout.
module tb_led_instr_issuer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        w_key_1 = 1'b1;
    logic        w_key_2 = 1'b1;
    logic        w_key_3 = 1'b1;
    logic        w_key_4 = 1'b1;
    logic        w_done = 1'b0;
    logic        w_start;
    logic [23:0] w_instruction;
    logic        w_busy;
    logic        w_timeout;
    int          tests = 0;
    int          fails = 0;
    int          n_start = 0;
    logic [7:0]  pat;

    led_instr_issuer #(
        .p_frequency(1000),
        .p_debounce_ms(4),
        .p_timeout_ms(20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .w_key_1(w_key_1),
        .w_key_2(w_key_2),
        .w_key_3(w_key_3),
        .w_key_4(w_key_4),
        .w_done(w_done),
        .w_start(w_start),
        .w_instruction(w_instruction),
        .w_busy(w_busy),
        .w_timeout(w_timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (w_start) n_start++;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic finish_req;
        w_done = 1'b1;
        tick();
        w_done = 1'b0;
        chk("done_busy_low", 32'(w_busy), 0);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        ticks(2);
        chk("rst_start", 32'(w_start), 0);
        chk("rst_busy", 32'(w_busy), 0);
        chk("rst_timeout", 32'(w_timeout), 0);
        chk("rst_instr", 32'(w_instruction), 0);
        rst = 1'b0;
        ticks(8);
        chk("idle_no_event", 32'(n_start), 0);

        w_key_2 = 1'b0;
        ticks(6);
        chk("k2_no_early_start", 32'(w_start), 0);
        tick();
        chk("k2_start", 32'(w_start), 1);
        chk("k2_busy_issue", 32'(w_busy), 1);
        chk("k2_instr", 32'(w_instruction), 32'h02_20_FF);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("k2_wait_busy", 32'(w_busy), 1);
            chk("k2_wait_start", 32'(w_start), 0);
        end
        w_done = 1'b1;
        chk("k2_busy_with_done", 32'(w_busy), 1);
        tick();
        w_done = 1'b0;
        chk("k2_busy_after_done", 32'(w_busy), 0);
        tick();
        chk("k2_idle_busy", 32'(w_busy), 0);
        chk("k2_instr_hold", 32'(w_instruction), 32'h02_20_FF);
        chk("k2_one_start", 32'(n_start), 1);
        w_key_2 = 1'b1;
        ticks(10);
        chk("k2_release_no_event", 32'(n_start), 1);

        pat = 8'b0000_0101;
        for (int i = 0; i < 8; i++) begin
            w_key_1 = pat[i];
            tick();
            chk("bounce_quiet", 32'(w_start), 0);
        end
        tick();
        chk("bounce_quiet_e8", 32'(w_start), 0);
        tick();
        chk("bounce_start", 32'(w_start), 1);
        chk("bounce_instr", 32'(w_instruction), 32'h01_08_04);
        tick();
        finish_req();
        ticks(5);
        chk("bounce_one_start", 32'(n_start), 2);
        w_key_1 = 1'b1;
        ticks(10);

        w_key_3 = 1'b0;
        w_key_4 = 1'b0;
        ticks(6);
        chk("k34_no_early_start", 32'(w_start), 0);
        tick();
        chk("k34_start", 32'(w_start), 1);
        chk("k34_instr", 32'(w_instruction), 32'h03_01_04);
        tick();
        finish_req();
        ticks(10);
        chk("k34_key4_dropped", 32'(n_start), 3);
        chk("k34_instr_hold", 32'(w_instruction), 32'h03_01_04);
        w_key_3 = 1'b1;
        w_key_4 = 1'b1;
        ticks(10);

        w_key_4 = 1'b0;
        ticks(7);
        chk("k4_start", 32'(w_start), 1);
        chk("k4_instr", 32'(w_instruction), 32'h04_08_04);
        tick();
        for (int i = 0; i < 20; i++) begin
            chk("k4_no_early_timeout", 32'(w_timeout), 0);
            chk("k4_busy_wait", 32'(w_busy), 1);
            tick();
        end
        chk("k4_timeout", 32'(w_timeout), 1);
        chk("k4_busy_timeout", 32'(w_busy), 0);
        tick();
        chk("k4_timeout_one_cycle", 32'(w_timeout), 0);
        chk("k4_idle_busy", 32'(w_busy), 0);
        chk("k4_idle_start", 32'(w_start), 0);
        w_key_4 = 1'b1;
        ticks(10);
        chk("k4_one_start", 32'(n_start), 4);

        w_key_1 = 1'b0;
        ticks(7);
        chk("drop_first_start", 32'(w_start), 1);
        tick();
        w_key_2 = 1'b0;
        ticks(10);
        chk("drop_no_second_start", 32'(n_start), 5);
        chk("drop_instr_kept", 32'(w_instruction), 32'h01_08_04);
        chk("drop_busy", 32'(w_busy), 1);
        finish_req();
        ticks(10);
        chk("drop_not_queued", 32'(n_start), 5);
        chk("drop_instr_after", 32'(w_instruction), 32'h01_08_04);
        w_key_1 = 1'b1;
        w_key_2 = 1'b1;
        ticks(10);

        w_key_3 = 1'b0;
        ticks(7);
        chk("abort_start", 32'(w_start), 1);
        ticks(4);
        chk("abort_busy_pre", 32'(w_busy), 1);
        rst = 1'b1;
        w_key_3 = 1'b1;
        tick();
        rst = 1'b0;
        w_done = 1'b1;
        for (int i = 0; i < 25; i++) begin
            chk("abort_start_low", 32'(w_start), 0);
            chk("abort_busy_low", 32'(w_busy), 0);
            chk("abort_timeout_low", 32'(w_timeout), 0);
            chk("abort_instr_zero", 32'(w_instruction), 0);
            tick();
            if (i == 2) w_done = 1'b0;
        end
        chk("abort_start_count", 32'(n_start), 6);

        w_key_1 = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("held_quiet", 32'(w_start), 0);
        end
        tick();
        chk("held_start", 32'(w_start), 1);
        chk("held_instr", 32'(w_instruction), 32'h01_08_04);
        tick();
        finish_req();
        ticks(10);
        chk("held_one_event", 32'(n_start), 7);
        w_key_1 = 1'b1;
        ticks(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
